// File: rtl/uart_work_loader.sv
// Assembles 44-byte miner work packets from UART byte strobes and presents
// them to the hashing core through a one-entry valid/ready output slot.
module uart_work_loader #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IDLE_W         = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         work_ready,
    output logic         work_valid,
    output logic [255:0] work_midstate,
    output logic [95:0]  work_data,
    output logic [5:0]   byte_count,
    output logic         overrun,
    output logic         timeout_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYCLES - 1);

    slot_e              slot_q, slot_d;
    // Only the newest 43 bytes can ever reach a packet, so no top byte is kept.
    logic [343:0]       sh_q, sh_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [255:0]       mid_q, mid_d;
    logic [95:0]        data_q, data_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;

    logic               take;
    logic               done;
    logic [351:0]       pkt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q <= EMPTY;
            sh_q   <= '0;
            cnt_q  <= '0;
            idle_q <= '0;
            mid_q  <= '0;
            data_q <= '0;
            ovr_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            mid_q  <= mid_d;
            data_q <= data_d;
            ovr_q  <= ovr_d;
            tmo_q  <= tmo_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        idle_d = idle_q;
        mid_d  = mid_q;
        data_d = data_q;
        ovr_d  = ovr_q;
        tmo_d  = 1'b0;
        take   = (slot_q == FULL) && work_ready;
        done   = rx_valid && (cnt_q == 6'd43);
        pkt    = {sh_q, rx_data};

        if (take) begin
            slot_d = EMPTY;
        end

        if (rx_valid) begin
            sh_d   = pkt[343:0];
            idle_d = '0;
            if (done) begin
                cnt_d = '0;
                if ((slot_q == EMPTY) || take) begin
                    slot_d = FULL;
                    mid_d  = pkt[351:96];
                    data_d = pkt[95:0];
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end else if (cnt_q == 6'd0) begin
            idle_d = '0;
        end else if (idle_q == IDLE_LIM) begin
            // Stalled sender: drop the partial packet and resync framing.
            cnt_d  = '0;
            idle_d = '0;
            tmo_d  = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    assign work_valid    = (slot_q == FULL);
    assign work_midstate = mid_q;
    assign work_data     = data_q;
    assign byte_count    = cnt_q;
    assign overrun       = ovr_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_uart_work_loader.sv
// Randomized bench for uart_work_loader against a packet-level reference
// model (byte queue, last-strobe timestamp, one-entry output slot).
module tb_uart_work_loader;

    localparam int T = 100;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         work_ready;
    logic         work_valid;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [5:0]   byte_count;
    logic         overrun;
    logic         timeout_err;

    always #5 clock = ~clock;

    uart_work_loader #(
        .TIMEOUT_CYCLES(T),
        .IDLE_W(7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .work_ready(work_ready),
        .work_valid(work_valid),
        .work_midstate(work_midstate),
        .work_data(work_data),
        .byte_count(byte_count),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]   q[$];
    bit           m_valid;
    logic [255:0] m_mid;
    logic [95:0]  m_data;
    bit           m_ovr;
    bit           m_tmo;
    int           edge_n;
    int           last_n;

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        m_mid   = '0;
        m_data  = '0;
        m_ovr   = 0;
        m_tmo   = 0;
        last_n  = edge_n;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
        logic [351:0] p;
        bit acc;
        acc = m_valid && r;
        edge_n++;
        m_tmo = 0;
        if (acc) m_valid = 0;
        if (v) begin
            q.push_back(d);
            last_n = edge_n;
            if (q.size() == 44) begin
                p = '0;
                for (int i = 0; i < 44; i++) p[351-8*i -: 8] = q[i];
                if (!m_valid) begin
                    m_valid = 1;
                    m_mid   = p[351:96];
                    m_data  = p[95:0];
                end else begin
                    m_ovr = 1;
                end
                q.delete();
            end
        end else if (q.size() != 0 && edge_n - last_n == T) begin
            q.delete();
            m_tmo = 1;
        end
    endtask

    task automatic compare_all();
        check("work_valid", 256'(work_valid), 256'(m_valid));
        check("work_midstate", work_midstate, m_mid);
        check("work_data", 256'(work_data), 256'(m_data));
        check("byte_count", 256'(byte_count), 256'(q.size()));
        check("overrun", 256'(overrun), 256'(m_ovr));
        check("timeout_err", 256'(timeout_err), 256'(m_tmo));
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        rx_valid   = v;
        rx_data    = d;
        work_ready = r;
        @(posedge clock);
        model_edge(v, d, r);
        #1;
        compare_all();
    endtask

    task automatic send_pkt(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1, 8'($urandom), r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 8'h00, r);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        work_ready = 1'b0;
        edge_n     = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;

        // Basic load, strobes 10 cycles apart
        for (int i = 0; i < 44; i++) begin
            step(1, 8'(i), 1);
            if (i != 43) idle(9, 1);
        end
        check("basic_valid", 256'(work_valid), 256'(1));
        check("basic_mid", work_midstate,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        check("basic_data", 256'(work_data), 256'(96'h202122232425262728292a2b));
        check("basic_cnt", 256'(byte_count), 256'(0));
        idle(1, 1);
        check("basic_pulse", 256'(work_valid), 256'(0));

        // Backpressure and overrun
        send_pkt(44, 0);
        send_pkt(44, 0);
        check("ovr_set", 256'(overrun), 256'(1));
        idle(1, 1);
        idle(1, 0);
        check("ovr_drain", 256'(work_valid), 256'(0));
        async_reset();

        // Next packet buffered while A is held
        send_pkt(44, 0);
        send_pkt(43, 0);
        step(1, 8'($urandom), 1);
        idle(3, 0);
        check("buf_valid", 256'(work_valid), 256'(1));
        check("buf_ovr", 256'(overrun), 256'(0));
        idle(2, 1);

        // Timeout then fresh packet
        send_pkt(5, 1);
        check("tmo_cnt5", 256'(byte_count), 256'(5));
        idle(120, 1);
        send_pkt(44, 1);
        idle(2, 1);

        // Byte lands exactly on the timeout cycle
        send_pkt(5, 1);
        idle(T - 1, 1);
        step(1, 8'h5a, 1);
        check("coll_cnt", 256'(byte_count), 256'(6));
        check("coll_tmo", 256'(timeout_err), 256'(0));
        idle(T + 5, 1);

        // Async reset mid-packet with work held
        send_pkt(44, 0);
        send_pkt(20, 0);
        async_reset();
        check("rst_valid", 256'(work_valid), 256'(0));
        send_pkt(44, 1);
        idle(2, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle($urandom_range(T - 5, T + 5), $urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 2) != 0, 8'($urandom),
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
